// File: rtl/fir_sample_scheduler.sv
// FIR sample scheduler: stores each ADC sample into a circular buffer,
// kicks the FIR MAC engine, waits (bounded) for its result and hands the
// result downstream through a valid/ready output register.
module fir_sample_scheduler #(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [15:0] TIMEOUT = 16'd12000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [17:0]       in_data,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [17:0]       buf_wdata,
  output logic [ADDR_W-1:0] buf_base,
  output logic              fir_start,
  input  logic              fir_done,
  input  logic [17:0]       fir_result,
  output logic              out_valid,
  output logic [17:0]       out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       overrun_count,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    START,
    WAIT_DONE,
    OUTPUT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] buf_base_q, buf_base_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_waddr_q, buf_waddr_d;
  logic [17:0]       buf_wdata_q, buf_wdata_d;
  logic              fir_start_q, fir_start_d;
  logic              out_valid_q, out_valid_d;
  logic [17:0]       out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic [15:0]       overrun_q, overrun_d;
  logic              timeout_err_q, timeout_err_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic              tmo_hit;

  // Expiry only matters while waiting; fir_done takes priority over it.
  assign tmo_hit = (tmo_cnt_q == (TIMEOUT - 16'd1));

  // State and all registered outputs; reset discards any in-flight work.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      buf_base_q    <= '0;
      buf_we_q      <= 1'b0;
      buf_waddr_q   <= '0;
      buf_wdata_q   <= '0;
      fir_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= '0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      buf_base_q    <= buf_base_d;
      buf_we_q      <= buf_we_d;
      buf_waddr_q   <= buf_waddr_d;
      buf_wdata_q   <= buf_wdata_d;
      fir_start_q   <= fir_start_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (in_valid) state_d = WRITE;
      WRITE:     state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (fir_done)     state_d = OUTPUT;
        else if (tmo_hit) state_d = IDLE;
      end
      OUTPUT:    if (out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  // Pulse outputs are computed one state early so they appear, registered,
  // during WRITE/START themselves.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    buf_base_d    = buf_base_q;
    buf_we_d      = 1'b0;
    buf_waddr_d   = buf_waddr_q;
    buf_wdata_d   = buf_wdata_q;
    fir_start_d   = 1'b0;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = tmo_cnt_q;
    busy_d        = (state_d != IDLE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_we_d    = 1'b1;
          buf_waddr_d = wr_ptr_q;
          buf_wdata_d = in_data;
        end
      end
      WRITE: begin
        buf_base_d  = wr_ptr_q;
        wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
        fir_start_d = 1'b1;
      end
      START: begin
        tmo_cnt_d = '0;
      end
      WAIT_DONE: begin
        if (fir_done) begin
          out_data_d  = fir_result;
          out_valid_d = 1'b1;
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      OUTPUT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase

    // No backpressure on the ADC side: strobes outside IDLE are lost.
    if (in_valid && (state_q != IDLE) && (overrun_q != '1))
      overrun_d = overrun_q + 16'd1;
  end

  assign buf_we        = buf_we_q;
  assign buf_waddr     = buf_waddr_q;
  assign buf_wdata     = buf_wdata_q;
  assign buf_base      = buf_base_q;
  assign fir_start     = fir_start_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign busy          = busy_q;
  assign overrun_count = overrun_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_fir_sample_scheduler.sv
// Directed bench for fir_sample_scheduler with a small scoreboard: expected
// buffer writes and output samples are queued when stimulus is driven and
// popped when the DUT presents them.
module tb_fir_sample_scheduler;

  localparam int unsigned AW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [17:0]   in_data;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [17:0]   buf_wdata;
  logic [AW-1:0] buf_base;
  logic          fir_start;
  logic          fir_done;
  logic [17:0]   fir_result;
  logic          out_valid;
  logic [17:0]   out_data;
  logic          out_ready;
  logic          busy;
  logic [15:0]   overrun_count;
  logic          timeout_err;

  fir_sample_scheduler #(.ADDR_W(AW), .TIMEOUT(16'd16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .buf_base(buf_base), .fir_start(fir_start),
    .fir_done(fir_done), .fir_result(fir_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .overrun_count(overrun_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [17:0]   data;
  } wr_t;

  wr_t         exp_wq[$];
  logic [17:0] exp_oq[$];
  logic [AW-1:0] exp_ptr;
  logic [AW-1:0] exp_base;
  logic [15:0]   exp_ovr;
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_ptr  = '0;
    exp_base = '0;
    exp_ovr  = '0;
    exp_wq.delete();
    exp_oq.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_buf_we"},    buf_we, 0);
    chk({tag, "_waddr"},     buf_waddr, 0);
    chk({tag, "_wdata"},     buf_wdata, 0);
    chk({tag, "_base"},      buf_base, 0);
    chk({tag, "_fir_start"}, fir_start, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_overrun"},   overrun_count, 0);
    chk({tag, "_tmo_err"},   timeout_err, 0);
  endtask

  // Strobe one sample from IDLE; returns one cycle into WAIT_DONE.
  task automatic do_write(input logic [17:0] d);
    wr_t e;
    in_valid = 1'b1;
    in_data  = d;
    exp_wq.push_back({exp_ptr, d});
    tick();
    in_valid = 1'b0;
    in_data  = 18'($urandom);
    e = exp_wq.pop_front();
    chk("write_we", buf_we, 1);
    chk("write_addr", buf_waddr, e.addr);
    chk("write_data", buf_wdata, e.data);
    chk("write_start_early", fir_start, 0);
    chk("write_base_hold", buf_base, exp_base);
    tick();
    chk("start_pulse", fir_start, 1);
    chk("start_we_low", buf_we, 0);
    chk("start_base", buf_base, e.addr);
    exp_base = e.addr;
    exp_ptr  = e.addr + 1'b1;
    tick();
    chk("wait_start_low", fir_start, 0);
    chk("wait_busy", busy, 1);
  endtask

  task automatic do_done(input logic [17:0] r);
    logic [17:0] e;
    fir_done   = 1'b1;
    fir_result = r;
    exp_oq.push_back(r);
    tick();
    fir_done   = 1'b0;
    fir_result = 18'($urandom);
    e = exp_oq.pop_front();
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, e);
  endtask

  task automatic do_accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("accept_valid_low", out_valid, 0);
    chk("accept_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] r;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    fir_done = 1'b0; fir_result = '0; out_ready = 1'b0;
    tick();
    apply_reset();
    check_reset_vals("reset");

    // Basic transaction at address 0.
    do_write(18'h00123);
    do_done(18'h0ABCD);
    do_accept();

    // fir_done while idle is ignored.
    fir_done = 1'b1; fir_result = 18'h3FFFF;
    tick();
    fir_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_valid", out_valid, 0);

    // Three strobes during WAIT_DONE are dropped.
    do_write(18'h2AAAA);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 18'h15555;
      tick();
      in_valid = 1'b0;
      exp_ovr++;
      chk("ovr_no_we", buf_we, 0);
      chk("ovr_base", buf_base, exp_base);
    end
    chk("ovr_count3", overrun_count, exp_ovr);
    do_done(18'h01234);
    do_accept();

    // Hold in OUTPUT with out_ready low; stray fir_done must not disturb it.
    do_write(18'h00777);
    r = 18'h2BEEF;
    do_done(r);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin fir_done = 1'b1; fir_result = ~r; end
      tick();
      fir_done = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, r);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 18'h00001;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    exp_ovr++;
    chk("release_valid", out_valid, 0);
    chk("release_idle", busy, 0);
    chk("release_no_we", buf_we, 0);
    chk("release_overrun", overrun_count, exp_ovr);

    // Timeout with no fir_done.
    do_write(18'h00042);
    repeat (15) begin
      tick();
      chk("tmo_wait_busy", busy, 1);
      chk("tmo_wait_err", timeout_err, 0);
    end
    tick();
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_no_valid", out_valid, 0);
    do_write(18'h00043);
    do_done(18'h00044);
    do_accept();
    chk("tmo_err_sticky", timeout_err, 1);

    // fir_done on the expiry cycle wins.
    apply_reset();
    check_reset_vals("reset2");
    do_write(18'h00050);
    repeat (15) tick();
    do_done(18'h00051);
    chk("expiry_done_err", timeout_err, 0);
    do_accept();

    // Reset during WAIT_DONE discards the transaction.
    do_write(18'h00060);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ptr = '0; exp_base = '0; exp_ovr = '0;
    fir_done = 1'b1; fir_result = 18'h00061;
    tick();
    fir_done = 1'b0;
    check_reset_vals("mid_reset");
    do_write(18'h00062);
    do_done(18'h00063);
    do_accept();

    // Full buffer wrap: 4097 samples from reset.
    apply_reset();
    for (int i = 0; i < 4097; i++) begin
      do_write(18'($urandom));
      do_done(18'($urandom));
      do_accept();
    end
    chk("wrap_base", buf_base, 0);
    chk("wrap_overrun", overrun_count, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
